simon_response_checker: RTL and testbench
=========================================

# simon_response_checker

Consumes the player's decoded button stream (`num` / `pressed` from the button interpreter) and compares it, step by step, against the sequence stored by the Simon generator. It reads that sequence back through a read-address port. It is armed by a start pulse when Simon finishes playback. It reports one-cycle `round_ok` or `fail` pulses, with a fail reason, which the game FSM uses to grow the sequence or enter game-over.

## Interface
Parameters:
- `DEBOUNCE`, 4: consecutive samples required to accept a press or release.
- `TIMEOUT`, 150_000_000: maximum `clk` cycles allowed in WAIT_PRESS (3 s at 50 MHz).
- `MAX_LEN`, 10: sequence memory depth.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle arm pulse from Simon.
- `length` in 4: number of steps in this round. Sampled when `start` is accepted.
- `seq_addr` out 4: index of the step being checked.
- `seq_num` in 2: sequence memory data. Combinational read: valid in the same cycle as `seq_addr`.
- `player_num` in 2: decoded button value.
- `player_pressed` in 1: any button held.
- `busy` out 1: round in progress.
- `progress` out 4: steps completed so far in the current round.
- `round_ok` out 1: one-cycle pulse when the whole round was entered correctly.
- `fail` out 1: one-cycle pulse when the round fails.
- `fail_code` out 2: fail reason. 01 = wrong button, 10 = timeout, 00 otherwise. Valid only while `fail` is high.

## Operation
All outputs are registered. `seq_addr` equals the internal index `idx`.

States:
- **IDLE**
  - `busy`=0.
  - `start` with `length` ≠ 0: latch `len` = min(`length`, `MAX_LEN`), clear `idx`, clear the timer and debounce counters, go to WAIT_PRESS.
  - `start` with `length`=0: ignored.
- **WAIT_PRESS**
  - The timer increments every cycle. The debounce counter increments while `player_pressed`=1 and clears while it is 0.
  - On the cycle the debounce count reaches `DEBOUNCE`, compare `player_num` with `seq_num` in that cycle:
    - Equal: go to WAIT_RELEASE.
    - Different: pulse `fail` with `fail_code`=01, go to IDLE.
  - If the timer reaches `TIMEOUT` without an accepted press: pulse `fail` with `fail_code`=10, go to IDLE.
  - If an accepted press and the timeout occur in the same cycle, the press wins.
- **WAIT_RELEASE**
  - No timeout applies; the player may hold the button indefinitely.
  - The debounce counter counts consecutive `player_pressed`=0 samples.
  - On reaching `DEBOUNCE`:
    - If `idx` = `len`−1: pulse `round_ok`, go to IDLE.
    - Otherwise: increment `idx`, clear the timer and debounce counter, go to WAIT_PRESS.
- `start` while `busy`=1 is ignored.
- Changes of `player_num` during WAIT_RELEASE are ignored.
- `progress` = `idx` while busy. It holds its final value in IDLE until the next accepted `start` or `reset`.
- The timer is 28 bits wide and saturating. The index and debounce counters never wrap, because their state exits bound them.

## Timing
Reset values: all outputs 0, state IDLE, all counters 0.

- **Start accept:** `start` sampled at edge N → `busy`=1 and `seq_addr`=0 after edge N. The first press sample is at edge N+1.
- **Press accept:** `player_pressed` high at edges k .. k+`DEBOUNCE`−1 → the comparison happens at edge k+`DEBOUNCE`−1. A resulting `fail` is visible for exactly one cycle after that edge.
- **Glitches:** a press or release shorter than `DEBOUNCE` samples has no effect.
- **Round end:** `round_ok` or `fail` and `busy`=0 appear in the same cycle. `start` can be accepted again on the next edge.
- **Timeout:** `fail` (code 10) is asserted after edge N+`TIMEOUT`, where N is the edge that entered WAIT_PRESS.
- **Mid-round reset:** `reset` wins over everything. On the next edge the block returns to IDLE, all outputs are 0, and no pulse is emitted.

## Test plan
All scenarios use `DEBOUNCE`=4 and `TIMEOUT`=20.

1. **Correct round:** `length`=3, seq {2,0,3}. Press 2, 0, 3, each held 6 cycles with 6-cycle releases → `progress` steps 0→1→2; a single `round_ok` pulse after the 4th low sample of the last release; `fail` stays 0.
2. **Wrong button:** seq {1,…}. Press 2 held 5 cycles → `fail`=1 with `fail_code`=01 for one cycle after the 4th high sample; `busy`=0 in the same cycle.
3. **Debounce:** press 3 cycles, release 2, then press 4 cycles → only the 4-cycle press is evaluated; the first glitch causes no `fail` and no advance.
4. **Timeout:** no press after start → `fail` with `fail_code`=10 exactly 20 cycles after WAIT_PRESS entry. An accepted press landing on cycle 20 instead advances normally.
5. **Mid-round reset:** assert `reset` during WAIT_RELEASE with `progress`=1 → next cycle `busy`=0, `progress`=0, no pulse. A new `start` then runs a full round correctly.
6. **Start guards:** `start` with `length`=0 is ignored. `start` while busy is ignored. `length`=12 clamps to 10, so `round_ok` comes only after 10 correct steps.

Source files
------------

// File: rtl/simon_response_checker.sv
// simon_response_checker: debounced step-by-step comparison of the
// player's button stream against the stored Simon sequence.
module simon_response_checker #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 150_000_000,
    parameter int MAX_LEN  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] length,
    output logic [3:0] seq_addr,
    input  logic [1:0] seq_num,
    input  logic [1:0] player_num,
    input  logic       player_pressed,
    output logic       busy,
    output logic [3:0] progress,
    output logic       round_ok,
    output logic       fail,
    output logic [1:0] fail_code
);

    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [27:0]   TMO_LAST = 28'(TIMEOUT - 1);
    localparam logic [27:0]   TMR_MAX  = '1;
    localparam logic [3:0]    LEN_MAX  = 4'(MAX_LEN);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_WRONG = 2'b01;
    localparam logic [1:0] CODE_TIME  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [3:0]    len;
    logic [3:0]    len_nx;
    logic [3:0]    idx;
    logic [3:0]    idx_nx;
    logic [27:0]   timer;
    logic [27:0]   timer_nx;
    logic [DW-1:0] deb;
    logic [DW-1:0] deb_nx;

    logic          busy_nx;
    logic          round_ok_nx;
    logic          fail_nx;
    logic [1:0]    fail_code_nx;

    logic          arm;
    logic [3:0]    len_clamp;
    logic [27:0]   timer_inc;
    logic [DW-1:0] deb_inc;
    logic          press_hit;
    logic          release_hit;
    logic          time_up;
    logic          last_step;
    logic          match;

    // Decode the conditions the state machine branches on.
    always_comb begin
        arm         = start && (length != 4'd0);
        len_clamp   = (length > LEN_MAX) ? LEN_MAX : length;
        timer_inc   = (timer == TMR_MAX) ? timer : timer + 28'd1;
        deb_inc     = deb + DEB_ONE;
        press_hit   = player_pressed && (deb == DEB_LAST);
        release_hit = !player_pressed && (deb == DEB_LAST);
        time_up     = (timer >= TMO_LAST);
        last_step   = (idx == (len - 4'd1));
        match       = (player_num == seq_num);
    end

    // Next-state, counter updates and result pulses.
    always_comb begin
        state_nx     = state;
        len_nx       = len;
        idx_nx       = idx;
        timer_nx     = timer;
        deb_nx       = deb;
        round_ok_nx  = 1'b0;
        fail_nx      = 1'b0;
        fail_code_nx = CODE_NONE;

        unique case (state)
            IDLE: begin
                if (arm) begin
                    len_nx   = len_clamp;
                    idx_nx   = 4'd0;
                    timer_nx = 28'd0;
                    deb_nx   = '0;
                    state_nx = WAIT_PRESS;
                end
            end

            WAIT_PRESS: begin
                timer_nx = timer_inc;
                deb_nx   = player_pressed ? deb_inc : '0;
                // A press accepted on the timeout cycle still counts.
                unique case (1'b1)
                    press_hit && match: begin
                        deb_nx   = '0;
                        state_nx = WAIT_RELEASE;
                    end
                    press_hit && !match: begin
                        deb_nx       = '0;
                        fail_nx      = 1'b1;
                        fail_code_nx = CODE_WRONG;
                        state_nx     = IDLE;
                    end
                    !press_hit && time_up: begin
                        fail_nx      = 1'b1;
                        fail_code_nx = CODE_TIME;
                        state_nx     = IDLE;
                    end
                    default: ;
                endcase
            end

            WAIT_RELEASE: begin
                deb_nx = player_pressed ? '0 : deb_inc;
                if (release_hit) begin
                    deb_nx = '0;
                    if (last_step) begin
                        round_ok_nx = 1'b1;
                        state_nx    = IDLE;
                    end else begin
                        idx_nx   = idx + 4'd1;
                        timer_nx = 28'd0;
                        state_nx = WAIT_PRESS;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len       <= 4'd0;
            idx       <= 4'd0;
            timer     <= 28'd0;
            deb       <= '0;
            busy      <= 1'b0;
            round_ok  <= 1'b0;
            fail      <= 1'b0;
            fail_code <= CODE_NONE;
        end else begin
            state     <= state_nx;
            len       <= len_nx;
            idx       <= idx_nx;
            timer     <= timer_nx;
            deb       <= deb_nx;
            busy      <= busy_nx;
            round_ok  <= round_ok_nx;
            fail      <= fail_nx;
            fail_code <= fail_code_nx;
        end
    end

    // The step index doubles as read address and progress count.
    assign seq_addr = idx;
    assign progress = idx;

endmodule

// File: tb/tb_simon_response_checker.sv
// tb_simon_response_checker: directed rounds with a queue of
// expected round_ok/fail pulses checked by an independent monitor.
module tb_simon_response_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] length;
    logic [3:0] seq_addr;
    logic [1:0] seq_num;
    logic [1:0] player_num;
    logic       player_pressed;
    logic       busy;
    logic [3:0] progress;
    logic       round_ok;
    logic       fail;
    logic [1:0] fail_code;

    logic [1:0] mem [16];

    int cyc;
    int total;
    int passes;

    typedef struct {
        bit       ok;
        bit [1:0] code;
        bit [3:0] prog;
        int       cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    simon_response_checker #(
        .DEBOUNCE(4),
        .TIMEOUT (20),
        .MAX_LEN (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .length        (length),
        .seq_addr      (seq_addr),
        .seq_num       (seq_num),
        .player_num    (player_num),
        .player_pressed(player_pressed),
        .busy          (busy),
        .progress      (progress),
        .round_ok      (round_ok),
        .fail          (fail),
        .fail_code     (fail_code)
    );

    assign seq_num = mem[seq_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic expect_ev(input bit ok, input bit [1:0] code,
                             input bit [3:0] prog, input int at);
        exp_t x;
        x.ok   = ok;
        x.code = code;
        x.prog = prog;
        x.cyc  = at;
        exp_q.push_back(x);
    endtask

    // Every task starts and ends just after a falling edge.
    task automatic do_start(input logic [3:0] l, output int n);
        start  = 1'b1;
        length = l;
        @(negedge clk);
        start  = 1'b0;
        n      = cyc;
    endtask

    task automatic press(input logic [1:0] v, input int h);
        player_num     = v;
        player_pressed = 1'b1;
        repeat (h) @(negedge clk);
    endtask

    task automatic release_btn(input int h);
        player_pressed = 1'b0;
        repeat (h) @(negedge clk);
    endtask

    task automatic idle(input int h);
        repeat (h) @(negedge clk);
    endtask

    // Monitor: every result pulse must match the next expectation.
    always @(negedge clk) begin
        if (round_ok || fail) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_pulse: got ok=%0d fail=%0d code=%0d at cycle %0d, expected none",
                         round_ok, fail, fail_code, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", int'(round_ok), int'(e.ok));
                check("pulse_excl", int'(round_ok & fail), 0);
                check("fail_code", int'(fail_code), int'(e.code));
                check("busy_at_end", int'(busy), 0);
                check("end_progress", int'(progress), int'(e.prog));
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int seq10[10];
        total          = 0;
        passes         = 0;
        reset          = 1'b1;
        start          = 1'b0;
        length         = 4'd0;
        player_num     = 2'd0;
        player_pressed = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;

        idle(3);
        check("rst_busy", int'(busy), 0);
        check("rst_progress", int'(progress), 0);
        check("rst_seq_addr", int'(seq_addr), 0);
        check("rst_round_ok", int'(round_ok), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_fail_code", int'(fail_code), 0);
        reset = 1'b0;
        idle(2);

        // Correct round {2,0,3}, 6-cycle holds and releases.
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        do_start(4'd3, n);
        check("s1_busy", int'(busy), 1);
        check("s1_addr0", int'(seq_addr), 0);
        expect_ev(1'b1, 2'b00, 4'd2, n + 34);
        press(2'd2, 6);
        check("s1_prog0", int'(progress), 0);
        release_btn(6);
        check("s1_prog1", int'(progress), 1);
        check("s1_addr1", int'(seq_addr), 1);
        press(2'd0, 6);
        release_btn(6);
        check("s1_prog2", int'(progress), 2);
        press(2'd3, 6);
        release_btn(6);
        check("s1_idle", int'(busy), 0);
        check("s1_hold", int'(progress), 2);

        // Wrong button on the first step.
        mem[0] = 2'd1; mem[1] = 2'd2;
        do_start(4'd2, n);
        expect_ev(1'b0, 2'b01, 4'd0, n + 4);
        press(2'd2, 5);
        release_btn(3);
        check("s2_idle", int'(busy), 0);

        // A 3-cycle wrong glitch must be ignored.
        mem[0] = 2'd3;
        do_start(4'd1, n);
        press(2'd0, 3);
        release_btn(2);
        check("s3_busy", int'(busy), 1);
        check("s3_prog", int'(progress), 0);
        expect_ev(1'b1, 2'b00, 4'd0, n + 13);
        press(2'd3, 4);
        release_btn(4);

        // Timeout with no press at all.
        do_start(4'd1, n);
        expect_ev(1'b0, 2'b10, 4'd0, n + 20);
        idle(22);
        check("s4_idle", int'(busy), 0);

        // Press accepted on the timeout cycle wins.
        mem[0] = 2'd2;
        do_start(4'd1, n);
        idle(16);
        press(2'd2, 4);
        check("s4_press_wins", int'(busy), 1);
        expect_ev(1'b1, 2'b00, 4'd0, n + 24);
        release_btn(4);

        // Timer restarts after each step.
        mem[0] = 2'd1; mem[1] = 2'd3;
        do_start(4'd2, n);
        expect_ev(1'b0, 2'b10, 4'd1, n + 28);
        press(2'd1, 4);
        release_btn(4);
        idle(22);

        // Reset during the second step's release.
        mem[0] = 2'd1; mem[1] = 2'd2;
        do_start(4'd2, n);
        press(2'd1, 4);
        release_btn(4);
        press(2'd2, 4);
        check("s5_prog", int'(progress), 1);
        reset = 1'b1;
        idle(1);
        check("s5_busy", int'(busy), 0);
        check("s5_prog0", int'(progress), 0);
        check("s5_addr0", int'(seq_addr), 0);
        reset = 1'b0;
        release_btn(4);
        do_start(4'd2, n);
        expect_ev(1'b1, 2'b00, 4'd1, n + 16);
        press(2'd1, 4);
        release_btn(4);
        press(2'd2, 4);
        release_btn(4);

        // Zero-length start is ignored.
        do_start(4'd0, n);
        check("s6_len0", int'(busy), 0);
        idle(25);

        // Start while busy must not restart the round.
        mem[0] = 2'd0; mem[1] = 2'd3;
        do_start(4'd2, n);
        expect_ev(1'b1, 2'b00, 4'd1, n + 17);
        press(2'd0, 4);
        release_btn(4);
        do_start(4'd5, n);
        check("s6_busy_start", int'(busy), 1);
        check("s6_busy_prog", int'(progress), 1);
        press(2'd3, 4);
        release_btn(4);

        // Length 12 clamps to 10 steps.
        seq10 = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2};
        for (int i = 0; i < 10; i++) mem[i] = 2'(seq10[i]);
        mem[10] = 2'd3; mem[11] = 2'd0;
        do_start(4'd12, n);
        expect_ev(1'b1, 2'b00, 4'd9, n + 80);
        for (int i = 0; i < 10; i++) begin
            press(2'(seq10[i]), 4);
            if (i == 9) begin
                check("s6_step9_busy", int'(busy), 1);
                check("s6_step9_prog", int'(progress), 9);
            end
            release_btn(4);
        end
        check("s6_clamp_idle", int'(busy), 0);

        idle(5);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
